fifo_axis_reader: RTL and testbench
===================================

# fifo_axis_reader

Read-side drain stage for the asynchronous FIFO. It runs in the FIFO's read clock domain and issues read requests against the FIFO's registered read port. It presents the returned words as an AXI4-Stream master with full valid/ready backpressure, and keeps packet statistics. A 2-entry output buffer absorbs the FIFO's one-cycle read latency, so the stream sustains one beat per cycle.

## Interface
- DATA_WIDTH, 8, width of the data word (matches the FIFO).
- CNT_WIDTH, 16, width of the packet and beat counters.
- m_clk  in  1  read-domain clock; only clock in the block.
- m_rst_n  in  1  reset, asynchronous, active-low.
- fifo_empty  in  1  FIFO empty flag.
- fifo_tdata  in  DATA_WIDTH  FIFO read data; valid the cycle after an accepted read.
- fifo_tlast  in  1  FIFO read last flag; same timing as fifo_tdata.
- fifo_rd_en  out  1  FIFO read request.
- m_axis_tvalid  out  1  stream beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_WIDTH  stream data.
- m_axis_tlast  out  1  end of packet.
- pkt_count  out  CNT_WIDTH  packets completed; wraps modulo 2^CNT_WIDTH.
- beat_count  out  CNT_WIDTH  beats accepted in the current packet; saturates at all-ones.
- last_pkt_len  out  CNT_WIDTH  beat length of the most recently completed packet; saturates.

## Operation
- State:
  - 2-entry buffer of {tdata, tlast}, organised as head and tail.
  - occ: 0..2, number of occupied buffer entries.
  - pending: 1 bit, a read was accepted by the FIFO last cycle.
- pop = m_axis_tvalid && m_axis_tready.
- fifo_rd_en = !fifo_empty && (occ + pending − pop) < 2.
  - Never asserted while fifo_empty = 1.
  - Combinational path m_axis_tready → fifo_rd_en is permitted.
- pending_next = fifo_rd_en. An issued request is always accepted because fifo_rd_en already includes !fifo_empty.
- When pending = 1, capture {fifo_tdata, fifo_tlast} into the buffer this cycle.
- Buffer update per cycle, by (pending, pop):
  - (1,0): write at position occ; occ+1.
  - (0,1): shift tail to head; occ−1.
  - (1,1): write at position occ−1 after the shift; occ unchanged.
  - (0,0): hold.
- occ + pending ≤ 2 always holds. No overflow is possible, so there is no drop path.
- Outputs:
  - m_axis_tvalid = (occ != 0).
  - m_axis_tdata and m_axis_tlast come from the head entry.
  - While m_axis_tvalid = 1 and pop = 0, head data stays stable (AXI rule).
- Counters, updated on pop:
  - tlast = 0: beat_count+1, saturating.
  - tlast = 1: last_pkt_len = beat_count+1 (saturating), beat_count = 0, pkt_count+1 (wrapping).
- Reset (asynchronous, m_rst_n = 0):
  - occ = 0, pending = 0, buffer data = 0.
  - m_axis_tvalid = 0, m_axis_tdata = 0, m_axis_tlast = 0.
  - fifo_rd_en is driven 0 while reset is held.
  - pkt_count = 0, beat_count = 0, last_pkt_len = 0.
  - A read in flight at reset is discarded. The FIFO is reset in the same domain.

## Timing
- Read latency:
  - fifo_rd_en = 1 in cycle N → data on fifo_tdata in N+1 → captured at the end of N+1.
  - m_axis_tvalid = 1 in N+2.
  - Minimum FIFO-to-stream latency: 2 cycles.
- Throughput: with fifo_empty = 0 and m_axis_tready = 1 held, one beat per cycle after the initial 2-cycle fill.
- Backpressure:
  - m_axis_tready = 0 with occ = 2 → fifo_rd_en = 0 next cycle onward.
  - At most one outstanding read is ever in flight.
- Simultaneous pop and capture in the same cycle: occ unchanged, order preserved.
- Counters, m_axis_* and occ are registered. fifo_rd_en is combinational.

## Test plan
- Reset mid-stream:
  - Stimulus: 3 beats buffered, then assert m_rst_n = 0.
  - Response: m_axis_tvalid = 0 immediately (asynchronously), all counters 0, fifo_rd_en = 0 while reset is held.
- Single word:
  - Stimulus: FIFO holds 0xA5 with tlast = 1; m_axis_tready = 1.
  - Response: fifo_rd_en for one cycle; m_axis_tvalid two cycles later with tdata = 0xA5 and tlast = 1; then pkt_count = 1, last_pkt_len = 1.
- Streaming:
  - Stimulus: 16 words 0x00..0x0F, tlast on 0x0F; m_axis_tready held at 1.
  - Response: 16 consecutive valid beats in order, no bubbles after the first; pkt_count = 1, last_pkt_len = 16.
- Backpressure:
  - Stimulus: same 16 words; m_axis_tready toggles pseudo-randomly.
  - Response:
    - No loss, duplication or reordering.
    - fifo_rd_en never asserted when occ + pending − pop = 2, or when fifo_empty = 1.
    - Head stable while stalled.
- Counter boundaries (CNT_WIDTH = 4):
  - Stimulus: a 20-beat packet, then 16 one-beat packets.
  - Response: beat_count saturates at 15; last_pkt_len = 15; pkt_count wraps to 1.

Source files
------------

// File: rtl/fifo_axis_reader_if.sv
// AXI4-Stream beat channel (valid/ready, data, last) between the FIFO reader
// and its downstream consumer.
interface fifo_axis_reader_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/fifo_axis_reader.sv
// Read-side drain of the async FIFO: issues reads against the registered read
// port, buffers returned words in a 2-entry skid, and streams them out as AXIS.
module fifo_axis_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  m_clk,
  input  logic                  m_rst_n,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_tdata,
  input  logic                  fifo_tlast,
  output logic                  fifo_rd_en,
  fifo_axis_reader_if.master    m_axis,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [CNT_WIDTH-1:0]  beat_count,
  output logic [CNT_WIDTH-1:0]  last_pkt_len
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] head_data, tail_data;
  logic                  head_last, tail_last;
  logic [1:0]            occ;
  logic                  pending;
  logic                  pop;
  logic [2:0]            level;
  logic [CNT_WIDTH-1:0]  beat_inc;

  assign m_axis.tvalid = (occ != 2'd0);
  assign m_axis.tdata  = head_data;
  assign m_axis.tlast  = head_last;

  assign pop = m_axis.tvalid && m_axis.tready;

  // Entries committed next cycle: buffered + in flight - leaving now. Never negative,
  // since pop implies occ >= 1.
  assign level      = {1'b0, occ} + {2'b00, pending} - {2'b00, pop};
  assign fifo_rd_en = m_rst_n && !fifo_empty && (level < 3'd2);

  assign beat_inc = (beat_count == CNT_MAX) ? CNT_MAX : beat_count + CNT_ONE;

  always_ff @(posedge m_clk or negedge m_rst_n) begin
    if (!m_rst_n) begin
      head_data    <= '0;
      head_last    <= 1'b0;
      tail_data    <= '0;
      tail_last    <= 1'b0;
      occ          <= 2'd0;
      pending      <= 1'b0;
      pkt_count    <= '0;
      beat_count   <= '0;
      last_pkt_len <= '0;
    end else begin
      pending <= fifo_rd_en;

      unique case ({pending, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            head_data <= fifo_tdata;
            head_last <= fifo_tlast;
          end else begin
            tail_data <= fifo_tdata;
            tail_last <= fifo_tlast;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head_data <= tail_data;
          head_last <= tail_last;
          occ       <= occ - 2'd1;
        end
        2'b11: begin
          // Shift and refill in one step so ordering survives a same-cycle pop.
          if (occ == 2'd1) begin
            head_data <= fifo_tdata;
            head_last <= fifo_tlast;
          end else begin
            head_data <= tail_data;
            head_last <= tail_last;
            tail_data <= fifo_tdata;
            tail_last <= fifo_tlast;
          end
        end
        default: ;
      endcase

      if (pop) begin
        if (head_last) begin
          last_pkt_len <= beat_inc;
          beat_count   <= '0;
          pkt_count    <= pkt_count + CNT_ONE;
        end else begin
          beat_count <= beat_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Scoreboarded bench for fifo_axis_reader; a second instance with 4-bit
// counters runs in lockstep to exercise saturation and wrap.
module tb_fifo_axis_reader;

  logic       clk;
  logic       rst_n;
  logic       ready;
  logic       fifo_empty;
  logic [7:0] fifo_tdata;
  logic       fifo_tlast;
  logic       fifo_rd_en, rd_en_s;
  logic [15:0] pkt_count, beat_count, last_pkt_len;
  logic [3:0]  pkt_count_s, beat_count_s, last_pkt_len_s;

  fifo_axis_reader_if #(.DATA_WIDTH(8)) ax   ();
  fifo_axis_reader_if #(.DATA_WIDTH(8)) ax_s ();

  assign ax.tready   = ready;
  assign ax_s.tready = ready;

  fifo_axis_reader #(.DATA_WIDTH(8), .CNT_WIDTH(16)) u_dut (
    .m_clk(clk), .m_rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_tdata(fifo_tdata),
    .fifo_tlast(fifo_tlast), .fifo_rd_en(fifo_rd_en), .m_axis(ax),
    .pkt_count(pkt_count), .beat_count(beat_count), .last_pkt_len(last_pkt_len));

  fifo_axis_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_dut_s (
    .m_clk(clk), .m_rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_tdata(fifo_tdata),
    .fifo_tlast(fifo_tlast), .fifo_rd_en(rd_en_s), .m_axis(ax_s),
    .pkt_count(pkt_count_s), .beat_count(beat_count_s), .last_pkt_len(last_pkt_len_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // FIFO model with registered read port; fifo_empty derives from push/pop counts.
  logic [8:0] fq[$];
  logic [8:0] exp_q[$];
  int n_in  = 0;
  int n_out = 0;
  assign fifo_empty = (n_in == n_out);

  initial begin
    fifo_tdata = 8'h00;
    fifo_tlast = 1'b0;
  end

  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) begin
      logic [8:0] w;
      w = fq.pop_front();
      fifo_tdata <= w[7:0];
      fifo_tlast <= w[8];
      n_out      <= n_out + 1;
    end
  end

  task automatic push(input logic [8:0] w);
    fq.push_back(w);
    exp_q.push_back(w);
    n_in = n_in + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pops, read-request budget, head stability, lockstep.
  int         outst = 0;
  logic       mon_pop;
  logic       stall_v = 1'b0;
  logic [8:0] stall_w;

  always @(negedge clk) begin
    if (!rst_n) begin
      outst   = 0;
      stall_v = 1'b0;
    end else begin
      mon_pop = ax.tvalid && ax.tready;
      if (mon_pop) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", {23'd0, ax.tlast, ax.tdata}, 32'h1ff);
        end else begin
          logic [8:0] e;
          e = exp_q.pop_front();
          check("beat", {23'd0, ax.tlast, ax.tdata}, {23'd0, e});
        end
      end
      if (fifo_rd_en) begin
        check("rd_en_while_empty", 32'(fifo_empty), 32'd0);
        check("rd_en_budget", 32'(outst - int'(mon_pop) < 2), 32'd1);
      end
      if (stall_v) begin
        check("stall_valid_held", 32'(ax.tvalid), 32'd1);
        check("stall_head_stable", {23'd0, ax.tlast, ax.tdata}, {23'd0, stall_w});
      end
      stall_v = ax.tvalid && !ax.tready;
      stall_w = {ax.tlast, ax.tdata};
      check("lockstep", {21'd0, rd_en_s, ax_s.tvalid, ax_s.tlast, ax_s.tdata},
            {21'd0, fifo_rd_en, ax.tvalid, ax.tlast, ax.tdata});
      outst = outst + int'(fifo_rd_en) - int'(mon_pop);
    end
  end

  task automatic drain(input string name, input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && n_in == n_out && !ax.tvalid) break;
    end
    if (k == budget) check({name, "_drain_timeout"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic clear_fifo();
    fq.delete();
    exp_q.delete();
    n_in = n_out;
  endtask

  task automatic do_reset();
    tick();
    rst_n = 1'b0;
    clear_fifo();
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] READY_PAT = 32'hB4D2_6E39;

  initial begin
    int i;
    int k;
    logic [31:0] pat;
    rst_n = 1'b0;
    ready = 1'b0;
    #2;
    check("rst_tvalid", 32'(ax.tvalid), 32'd0);
    check("rst_tdata", 32'(ax.tdata), 32'd0);
    check("rst_tlast", 32'(ax.tlast), 32'd0);
    check("rst_counters", {pkt_count, beat_count}, 32'd0);
    check("rst_last_len", 32'(last_pkt_len), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;

    // Single word: rd_en in N, tvalid in N+2.
    ready = 1'b1;
    tick();
    push(9'h1A5);
    @(negedge clk);
    check("single_rd_en_N", 32'(fifo_rd_en), 32'd1);
    check("single_tvalid_N", 32'(ax.tvalid), 32'd0);
    @(negedge clk);
    check("single_rd_en_N1", 32'(fifo_rd_en), 32'd0);
    check("single_tvalid_N1", 32'(ax.tvalid), 32'd0);
    @(negedge clk);
    check("single_tvalid_N2", 32'(ax.tvalid), 32'd1);
    check("single_tdata", 32'(ax.tdata), 32'h0A5);
    check("single_tlast", 32'(ax.tlast), 32'd1);
    @(negedge clk);
    check("single_pkt_count", 32'(pkt_count), 32'd1);
    check("single_last_len", 32'(last_pkt_len), 32'd1);
    check("single_tvalid_after", 32'(ax.tvalid), 32'd0);

    // Streaming: 16 words, no bubbles once the first beat appears.
    tick();
    for (i = 0; i < 16; i++) push({(i == 15), 8'(i)});
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (ax.tvalid) break;
    end
    check("stream_first_valid", 32'(ax.tvalid), 32'd1);
    for (i = 1; i < 16; i++) begin
      @(negedge clk);
      check("stream_no_bubble", 32'(ax.tvalid), 32'd1);
    end
    drain("stream", 50);
    check("stream_pkt_count", 32'(pkt_count), 32'd2);
    check("stream_last_len", 32'(last_pkt_len), 32'd16);
    check("stream_beat_count", 32'(beat_count), 32'd0);

    // Reset mid-stream with beats buffered and stalled.
    tick();
    ready = 1'b0;
    push(9'h030);
    push(9'h031);
    push(9'h132);
    repeat (5) tick();
    check("pre_rst_tvalid", 32'(ax.tvalid), 32'd1);
    check("pre_rst_pkt_count", 32'(pkt_count), 32'd2);
    rst_n = 1'b0;
    #1;
    check("async_rst_tvalid", 32'(ax.tvalid), 32'd0);
    check("async_rst_counters", {pkt_count, beat_count}, 32'd0);
    check("async_rst_last_len", 32'(last_pkt_len), 32'd0);
    check("rst_rd_en_held", 32'(fifo_rd_en), 32'd0);
    repeat (2) tick();
    check("rst_rd_en_held2", 32'(fifo_rd_en), 32'd0);
    clear_fifo();
    tick();
    rst_n = 1'b1;

    // Backpressure: pseudo-random ready pattern.
    tick();
    for (i = 0; i < 16; i++) push({(i == 15), 8'(8'h10 + i)});
    pat = READY_PAT;
    for (k = 0; k < 300 && exp_q.size() != 0; k++) begin
      ready = pat[0];
      pat   = {pat[0], pat[31:1]};
      tick();
    end
    ready = 1'b1;
    drain("backpressure", 50);
    check("bp_pkt_count", 32'(pkt_count), 32'd1);
    check("bp_last_len", 32'(last_pkt_len), 32'd16);

    // Counter boundaries on the 4-bit instance.
    do_reset();
    ready = 1'b1;
    tick();
    for (i = 0; i < 19; i++) push({1'b0, 8'(8'h40 + i)});
    drain("cnt_body", 60);
    check("cnt_beat_sat", 32'(beat_count_s), 32'd15);
    check("cnt_beat_wide", 32'(beat_count), 32'd19);
    tick();
    push(9'h153);
    drain("cnt_tail", 20);
    check("cnt_last_len_sat", 32'(last_pkt_len_s), 32'd15);
    check("cnt_last_len_wide", 32'(last_pkt_len), 32'd20);
    check("cnt_beat_cleared", 32'(beat_count_s), 32'd0);
    check("cnt_pkt_one", 32'(pkt_count_s), 32'd1);
    tick();
    for (i = 0; i < 16; i++) push({1'b1, 8'(8'h80 + i)});
    drain("cnt_short", 60);
    check("cnt_pkt_wrap", 32'(pkt_count_s), 32'd1);
    check("cnt_pkt_wide", 32'(pkt_count), 32'd17);
    check("cnt_last_len_one", 32'(last_pkt_len_s), 32'd1);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
